// File: rtl/image_frame_loader.sv
// -----------------------------------------------------------------------------
// image_frame_loader
//
// Sits between the SPI byte receiver and the BNN inference core. It takes bytes
// over the rx_byte_valid / rx_byte_taken handshake and decodes a small command
// protocol:
//   CMD_START - the next NBYTES bytes are image data
//   CMD_CLEAR - zero the image buffer
// The bytes are packed into a flat bit buffer, MSB first. The finished image is
// held on image_bits / image_valid until the core pulses image_consumed.
// rx_enable is held low while a finished image is pending, so the receiver is
// throttled and no bytes are accepted during that time.
//
// Optional build macro LOADER_CHECKSUM_EN:
//   When defined, an XOR checksum byte must follow the image data. A match
//   presents the image. A mismatch pulses chk_err and discards the image.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   rx_byte          received byte, stable while rx_byte_valid is high
//   rx_byte_valid    receiver byte-ready level
//   rx_byte_taken    acknowledge to the receiver, held until valid drops
//   rx_enable        permits the receiver to shift bits (low in FULL)
//   image_bits       pixel buffer, pixel p = row*IMG_W+col at bit p
//   image_valid      a complete image is available (state FULL)
//   image_consumed   single-cycle pulse from the core, image taken
//   busy             high while loading image data
//   cmd_err          one-cycle pulse on an unknown command byte
//   chk_err          one-cycle pulse on a checksum mismatch (LOADER_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module image_frame_loader #(
    parameter int         IMG_W     = 28,
    parameter int         IMG_H     = 28,
    parameter logic [7:0] CMD_START = 8'hA5,
    parameter logic [7:0] CMD_CLEAR = 8'hC3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_byte_valid,
    output logic                   rx_byte_taken,
    output logic                   rx_enable,
    output logic [IMG_W*IMG_H-1:0] image_bits,
    output logic                   image_valid,
    input  logic                   image_consumed,
    output logic                   busy,
    output logic                   cmd_err
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                   chk_err
`endif
);

    localparam int NBITS  = IMG_W * IMG_H;
    localparam int NBYTES = (NBITS + 7) / 8;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam int PIX_W  = $clog2(NBITS);

    localparam logic [1:0] S_WAIT_CMD = 2'd0;
    localparam logic [1:0] S_LOAD     = 2'd1;
    localparam logic [1:0] S_FULL     = 2'd2;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [1:0] S_CHECK    = 2'd3;
`endif

    logic [1:0]       state;
    logic [IDX_W-1:0] byte_idx;
    logic             rbv_q;
    logic             capture;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       xor_q;
`endif

    // Outputs are plain decodes of the state. image_valid therefore rises the
    // cycle after the final capture and falls the cycle after image_consumed.
    assign busy        = (state == S_LOAD);
    assign image_valid = (state == S_FULL);
    assign rx_enable   = (state != S_FULL);

    // Only a rising edge of the valid level counts as a new byte. A level held
    // high is captured once. Bytes arriving while the image is pending are
    // ignored.
    assign capture = rx_byte_valid && !rbv_q && rx_enable;

    // NOTE: every register here is updated with <= so that each branch reads
    //       this cycle's values, whatever order the statements appear in.
    // NOTE: image_bits is a flop array, not RAM, and is reset with everything
    //       else. A reset in the middle of a load discards the partial image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_WAIT_CMD;
            byte_idx      <= '0;
            rbv_q         <= 1'b0;
            rx_byte_taken <= 1'b0;
            cmd_err       <= 1'b0;
            image_bits    <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q         <= 8'h00;
            chk_err       <= 1'b0;
`endif
        end else begin
            rbv_q   <= rx_byte_valid;
            cmd_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_err <= 1'b0;
`endif

            // The acknowledge rises after a capture and stays high until the
            // receiver drops its valid level.
            if (capture)
                rx_byte_taken <= 1'b1;
            else if (!rx_byte_valid)
                rx_byte_taken <= 1'b0;

            case (state)
                S_WAIT_CMD: begin
                    if (capture) begin
                        if (rx_byte == CMD_START) begin
                            byte_idx <= '0;
                            state    <= S_LOAD;
`ifdef LOADER_CHECKSUM_EN
                            xor_q    <= 8'h00;
`endif
                        end else if (rx_byte == CMD_CLEAR) begin
                            image_bits <= '0;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (capture) begin
                        // Byte k, bit 7-j lands on pixel 8k+j. Pixels past the
                        // end of the image, in a padded last byte, are dropped.
                        for (int j = 0; j < 8; j++) begin
                            if (int'(byte_idx) * 8 + j < NBITS)
                                image_bits[PIX_W'(int'(byte_idx) * 8 + j)] <= rx_byte[3'(7 - j)];
                        end
                        byte_idx <= byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        xor_q <= xor_q ^ rx_byte;
                        if (byte_idx == IDX_W'(NBYTES - 1))
                            state <= S_CHECK;
`else
                        if (byte_idx == IDX_W'(NBYTES - 1))
                            state <= S_FULL;
`endif
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (capture) begin
                        if (rx_byte == xor_q) begin
                            state <= S_FULL;
                        end else begin
                            chk_err    <= 1'b1;
                            image_bits <= '0;
                            state      <= S_WAIT_CMD;
                        end
                    end
                end
`endif

                S_FULL: begin
                    if (image_consumed)
                        state <= S_WAIT_CMD;
                end

                default: state <= S_WAIT_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_image_frame_loader
//
// Directed, self-checking bench for image_frame_loader with its default
// parameters (28x28 pixels, 98 bytes). Expected values are hand-computed
// constants. The bench also builds with LOADER_CHECKSUM_EN defined. In that
// build it appends the XOR byte to every image and exercises the mismatch path.
// -----------------------------------------------------------------------------
module tb_image_frame_loader;

    localparam int NBITS  = 784;
    localparam int NBYTES = 98;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       rx_byte = 8'h00;
    logic             rx_byte_valid = 1'b0;
    logic             rx_byte_taken;
    logic             rx_enable;
    logic [NBITS-1:0] image_bits;
    logic             image_valid;
    logic             image_consumed = 1'b0;
    logic             busy;
    logic             cmd_err;
`ifdef LOADER_CHECKSUM_EN
    logic             chk_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] img_bytes [NBYTES];

    image_frame_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_byte        (rx_byte),
        .rx_byte_valid  (rx_byte_valid),
        .rx_byte_taken  (rx_byte_taken),
        .rx_enable      (rx_enable),
        .image_bits     (image_bits),
        .image_valid    (image_valid),
        .image_consumed (image_consumed),
        .busy           (busy),
        .cmd_err        (cmd_err)
`ifdef LOADER_CHECKSUM_EN
        ,
        .chk_err        (chk_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NBITS-1:0] obs, input logic [NBITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timeout waiting on rx_byte_taken", tag);
    endtask

    // Drive a byte and return at the first falling edge where it is acked.
    task automatic present(input logic [7:0] b);
        @(negedge clk);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rx_byte_taken) return;
        end
        timeout("ack_rise");
    endtask

    task automatic release_byte();
        rx_byte_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!rx_byte_taken) return;
        end
        timeout("ack_fall");
    endtask

    task automatic send(input logic [7:0] b);
        present(b);
        release_byte();
    endtask

    task automatic consume();
        @(negedge clk);
        image_consumed = 1'b1;
        @(negedge clk);
        image_consumed = 1'b0;
        check("consume_valid", image_valid, 0);
        check("consume_rx_en", rx_enable, 1);
    endtask

    // Send CMD_START and img_bytes. Optionally hold byte 0 for 20 cycles, and
    // optionally pulse image_consumed together with the final byte.
    task automatic load_image(input bit hold_first, input bit consume_last);
        logic [7:0] x;
        logic [7:0] last_b;
        x = 8'h00;
        for (int k = 0; k < NBYTES; k++) x = x ^ img_bytes[k];
        send(8'hA5);
        for (int k = 0; k < NBYTES - 1; k++) begin
            present(img_bytes[k]);
            if (k == 0 && hold_first) begin
                repeat (19) @(negedge clk);
                check("hold_taken_high", rx_byte_taken, 1);
            end
            release_byte();
            if (k == 0 && hold_first)
                check("hold_taken_low", rx_byte_taken, 0);
        end
`ifdef LOADER_CHECKSUM_EN
        send(img_bytes[NBYTES-1]);
        last_b = x;
`else
        check("busy_before_last", busy, 1);
        last_b = img_bytes[NBYTES-1];
`endif
        check("valid_before_last", image_valid, 0);
        @(negedge clk);
        rx_byte        = last_b;
        rx_byte_valid  = 1'b1;
        image_consumed = consume_last;
        @(negedge clk);
        image_consumed = 1'b0;
        check("valid_after_last", image_valid, 1);
        check("rx_en_full", rx_enable, 0);
        check("busy_full", busy, 0);
        release_byte();
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_image", image_bits, 0);
        check("rst_valid", image_valid, 0);
        check("rst_taken", rx_byte_taken, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_rx_en", rx_enable, 1);
        rst_n = 1'b1;

        // 1: all-ones image.
        for (int k = 0; k < NBYTES; k++) img_bytes[k] = 8'hFF;
        load_image(1'b0, 1'b0);
        check("t1_image", image_bits, {NBITS{1'b1}});
        consume();
        check("t1_retained", image_bits, {NBITS{1'b1}});

        // 2: single pixel. image_consumed on the final capture is ignored.
        for (int k = 0; k < NBYTES; k++) img_bytes[k] = 8'h00;
        img_bytes[0] = 8'h80;
        load_image(1'b0, 1'b1);
        check("t2_image", image_bits, 784'h1);
        consume();

        // 3: byte 0 held high for 20 cycles is captured once. Pixels 0,1,15.
        img_bytes[0] = 8'hC0;
        img_bytes[1] = 8'h01;
        load_image(1'b1, 1'b0);
        check("t3_image", image_bits, 784'h8003);
        consume();

        // 4: unknown command, then clear.
        present(8'h3C);
        check("t4_cmd_err_pulse", cmd_err, 1);
        check("t4_busy", busy, 0);
        @(negedge clk);
        check("t4_cmd_err_drop", cmd_err, 0);
        release_byte();
        check("t4_rx_en", rx_enable, 1);
        send(8'hC3);
        check("t4_clear", image_bits, 0);
        // image_consumed outside FULL does nothing; A5 is still taken as a
        // command.
        @(negedge clk);
        image_consumed = 1'b1;
        @(negedge clk);
        image_consumed = 1'b0;
        send(8'hA5);
        check("t4_busy_load", busy, 1);

        // 5: 50 data bytes of 0x55 (pixel pattern 0xAA per byte), then reset.
        for (int k = 0; k < 50; k++) send(8'h55);
        check("t5_partial", image_bits, {{384{1'b0}}, {50{8'hAA}}});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_image", image_bits, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_valid", image_valid, 0);
        check("t5_rst_rx_en", rx_enable, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NBYTES; k++) img_bytes[k] = 8'hA5;
        load_image(1'b0, 1'b0);
        check("t5_image", image_bits, {NBYTES{8'hA5}});
        consume();

`ifdef LOADER_CHECKSUM_EN
        // 6: correct checksum reaches FULL (covered in load_image). Wrong one:
        for (int k = 0; k < NBYTES; k++) img_bytes[k] = 8'h00;
        img_bytes[0] = 8'hFF;
        load_image(1'b0, 1'b0);
        check("t6_image_ok", image_bits, 784'hFF);
        consume();
        send(8'hA5);
        for (int k = 0; k < NBYTES; k++) send(img_bytes[k]);
        present(8'hFE);
        check("t6_chk_err_pulse", chk_err, 1);
        check("t6_image_zero", image_bits, 0);
        check("t6_valid", image_valid, 0);
        @(negedge clk);
        check("t6_chk_err_drop", chk_err, 0);
        check("t6_valid_after", image_valid, 0);
        release_byte();
        check("t6_rx_en", rx_enable, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
